ud_cycle_counter_p: RTL and testbench

Parametrised up/down cycle counter: a register-programmed counter that sweeps preload → upper limit → lower limit → preload for a programmed number of cycles, then signals end-of-cycle. It is the next generation of the team's 8-bit up/down counter, with these additions:
- generic data width;
- separate read/write data buses instead of a tri-state bus;
- a control register with auto-restart and abort;
- a read-only status register;
- a `busy` output.

It sits on the local chip-select/read/write register bus.

---
 rtl/ud_cycle_counter_p.sv | 235 +++++++++++++++++++++++
 tb/tb_ud_cycle_counter_p.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ud_cycle_counter_p.sv
// ud_cycle_counter_p: register-programmed up/down cycle counter.
// Each run sweeps preload -> upper limit -> lower limit -> preload for CCR cycles,
// then pulses ec for one clock. Configuration sits behind a chip-select/read/write
// register bus with separate read and write data paths.
module ud_cycle_counter_p #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ncs,
   input  logic             nwr,
   input  logic             nrd,
   input  logic [2:0]       addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             start,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             err,
   output logic             ec,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [2:0] {
      A_PLR    = 3'd0,
      A_ULR    = 3'd1,
      A_LLR    = 3'd2,
      A_CCR    = 3'd3,
      A_CTRL   = 3'd4,
      A_STATUS = 3'd5
   } reg_addr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_RET,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] plr;
   logic [WIDTH-1:0] ulr;
   logic [WIDTH-1:0] llr;
   logic [WIDTH-1:0] ccr;
   logic             auto_rs;

   logic [WIDTH-1:0] cyc;
   logic [WIDTH-1:0] cyc_inc;
   logic [WIDTH-1:0] cyc_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] status;

   logic             start_pend;
   logic             wr_en;
   logic             rd_en;
   logic             abort_req;
   logic             start_ok;
   logic             cfg_lock;
   logic             at_boundary;
   logic             cycle_end;
   logic             last_cycle;

   assign err       = (plr < llr) | (plr > ulr) | (llr > ulr);
   assign wr_en     = ~ncs & ~nwr;
   assign rd_en     = ~ncs & ~nrd & nwr;
   assign abort_req = wr_en && (addr == A_CTRL) && din[1];
   assign start_ok  = start && ~ncs && nwr && (state == S_IDLE) && ~start_pend && ~err;
   // Limits stay frozen from start acceptance onwards so LOAD sees the checked values.
   assign cfg_lock  = busy | start_pend;
   assign cyc_inc   = cyc + ONE;
   assign status    = WIDTH'({cyc, ec, dir, err, busy});

   // Next count/state: every running clock either steps the count or finishes the run.
   // A state sitting on its turning value turns and steps in the same clock; the point
   // where count is back at PLR is resolved one clock later, which both closes the cycle
   // and makes the first step of the next one, so only the final cycle costs a clock.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      cyc_nxt     = cyc;
      at_boundary = 1'b0;
      cycle_end   = 1'b0;
      last_cycle  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start_pend) begin
               state_nxt = S_LOAD;
               count_nxt = plr;
               cyc_nxt   = '0;
            end
         end
         S_LOAD: begin
            at_boundary = 1'b1;
         end
         S_UP: begin
            if (count == ulr) begin
               state_nxt = S_DOWN;
               count_nxt = count - ONE;
            end else begin
               count_nxt = count + ONE;
            end
         end
         S_DOWN: begin
            if (count == llr) begin
               if (plr == llr) begin
                  at_boundary = 1'b1;
                  cycle_end   = 1'b1;
               end else begin
                  state_nxt = S_RET;
                  count_nxt = count + ONE;
               end
            end else begin
               count_nxt = count - ONE;
            end
         end
         S_RET: begin
            if (count == plr) begin
               at_boundary = 1'b1;
               cycle_end   = 1'b1;
            end else begin
               count_nxt = count + ONE;
            end
         end
         S_DONE: begin
            // An illegal configuration written during DONE must not be restarted.
            if (auto_rs && !err) begin
               state_nxt = S_LOAD;
               count_nxt = plr;
               cyc_nxt   = '0;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (at_boundary) begin
         if (cycle_end) begin
            cyc_nxt    = cyc_inc;
            last_cycle = (cyc_inc == ccr);
         end else begin
            last_cycle = (ccr == '0);
         end

         if (last_cycle) begin
            state_nxt = S_DONE;
         end else if (plr != ulr) begin
            state_nxt = S_UP;
            count_nxt = count + ONE;
         end else if (ulr != llr) begin
            state_nxt = S_DOWN;
            count_nxt = count - ONE;
         end else begin
            // All three limits equal: the cycle is one clock holding at PLR.
            state_nxt = S_DOWN;
         end
      end
   end

   // Sequencer state and registered run outputs; abort drops straight to IDLE holding count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         start_pend <= 1'b0;
         count      <= '0;
         cyc        <= '0;
         dir        <= 1'b0;
         ec         <= 1'b0;
         busy       <= 1'b0;
      end else if (abort_req) begin
         state      <= S_IDLE;
         start_pend <= 1'b0;
         dir        <= 1'b0;
         ec         <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         cyc        <= cyc_nxt;
         start_pend <= start_ok;
         dir        <= (state_nxt == S_UP) || (state_nxt == S_RET);
         ec         <= (state_nxt == S_DONE);
         busy       <= state_nxt inside {S_LOAD, S_UP, S_DOWN, S_RET};
      end
   end

   // Configuration registers; limits and CCR are write-protected during a run.
   always_ff @(posedge clk) begin
      if (reset) begin
         plr     <= ONE;
         ulr     <= '1;
         llr     <= '0;
         ccr     <= '0;
         auto_rs <= 1'b0;
      end else if (wr_en) begin
         case (addr)
            A_PLR:   if (!cfg_lock) plr <= din;
            A_ULR:   if (!cfg_lock) ulr <= din;
            A_LLR:   if (!cfg_lock) llr <= din;
            A_CCR:   if (!cfg_lock) ccr <= din;
            A_CTRL:  auto_rs <= din[0];
            default: ;
         endcase
      end
   end

   // Registered read port; idle, write and unmapped accesses return zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= '0;
      end else if (rd_en) begin
         case (addr)
            A_PLR:    dout <= plr;
            A_ULR:    dout <= ulr;
            A_LLR:    dout <= llr;
            A_CCR:    dout <= ccr;
            A_CTRL:   dout <= {{(WIDTH-1){1'b0}}, auto_rs};
            A_STATUS: dout <= status;
            default:  dout <= '0;
         endcase
      end else begin
         dout <= '0;
      end
   end

endmodule

// File: tb/tb_ud_cycle_counter_p.sv
// Self-checking bench for ud_cycle_counter_p: directed scenarios plus randomized runs
// checked against a sweep model built from the limit values.
module tb_ud_cycle_counter_p;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             ncs;
   logic             nwr;
   logic             nrd;
   logic [2:0]       addr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             start;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             err;
   logic             ec;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int tcount = 0;

   always #5 clk = ~clk;

   ud_cycle_counter_p #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .ncs   (ncs),
      .nwr   (nwr),
      .nrd   (nrd),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .start (start),
      .count (count),
      .dir   (dir),
      .err   (err),
      .ec    (ec),
      .busy  (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tcount++;
   endtask

   task automatic wr(input int a, input int d);
      ncs  = 1'b0;
      nwr  = 1'b0;
      addr = a[2:0];
      din  = d[WIDTH-1:0];
      tick();
      ncs  = 1'b1;
      nwr  = 1'b1;
   endtask

   task automatic rd(input int a, output logic [WIDTH-1:0] d);
      ncs  = 1'b0;
      nrd  = 1'b0;
      addr = a[2:0];
      tick();
      d    = dout;
      ncs  = 1'b1;
      nrd  = 1'b1;
   endtask

   task automatic go();
      ncs   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ncs   = 1'b1;
   endtask

   // Builds the expected count trajectory of a whole run and checks it edge by edge.
   task automatic check_run(input int p, input int u, input int l, input int c, input string tag);
      int               q[$];
      int               prev;
      logic [WIDTH-1:0] st;
      q = {};
      for (int n = 0; n < c; n++) begin
         if (u == l) begin
            q.push_back(p);
         end else begin
            for (int v = p + 1; v <= u; v++) q.push_back(v);
            for (int v = u - 1; v >= l; v--) q.push_back(v);
            for (int v = l + 1; v <= p; v++) q.push_back(v);
         end
      end
      go();
      tick();
      chk({tag, " load count"}, 32'(count), 32'(p));
      chk({tag, " load busy"}, 32'(busy), 32'd1);
      chk({tag, " load dir"}, 32'(dir), 32'd0);
      chk({tag, " load ec"}, 32'(ec), 32'd0);
      prev = p;
      foreach (q[i]) begin
         tick();
         chk({tag, " step count"}, 32'(count), 32'(q[i]));
         chk({tag, " step dir"}, 32'(dir), 32'(q[i] > prev));
         chk({tag, " step busy"}, 32'(busy), 32'd1);
         chk({tag, " step ec"}, 32'(ec), 32'd0);
         prev = q[i];
      end
      tick();
      chk({tag, " done ec"}, 32'(ec), 32'd1);
      chk({tag, " done busy"}, 32'(busy), 32'd0);
      chk({tag, " done count"}, 32'(count), 32'(p));
      chk({tag, " done dir"}, 32'(dir), 32'd0);
      tick();
      chk({tag, " after ec"}, 32'(ec), 32'd0);
      chk({tag, " after busy"}, 32'(busy), 32'd0);
      rd(5, st);
      chk({tag, " status"}, 32'(st), (32'(c) << 4) & 32'hff);
   endtask

   task automatic run_cfg(input int p, input int u, input int l, input int c, input string tag);
      wr(0, p);
      wr(1, u);
      wr(2, l);
      wr(3, c);
      check_run(p, u, l, c, tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] v;
      int               t0;
      int               c0;
      int               def_exp[6];
      int               cfg_exp[6];
      int               p;
      int               u;
      int               l;
      int               c;

      def_exp = '{1, 255, 0, 0, 0, 0};
      cfg_exp = '{10, 15, 5, 2, 0, 0};

      reset = 1'b1;
      ncs   = 1'b1;
      nwr   = 1'b1;
      nrd   = 1'b1;
      addr  = '0;
      din   = '0;
      start = 1'b0;
      tick();
      tick();
      chk("reset count", 32'(count), 32'd0);
      chk("reset dir", 32'(dir), 32'd0);
      chk("reset ec", 32'(ec), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset dout", 32'(dout), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 6; a++) begin
         rd(a, v);
         chk("default reg", 32'(v), 32'(def_exp[a]));
      end

      // Basic run with full register readback beforehand
      wr(0, 10);
      wr(1, 15);
      wr(2, 5);
      wr(3, 2);
      for (int a = 0; a < 6; a++) begin
         rd(a, v);
         chk("cfg reg", 32'(v), 32'(cfg_exp[a]));
      end
      check_run(10, 15, 5, 2, "basic");

      // Same run with bus traffic while busy
      go();
      t0 = tcount;
      tick();
      wr(1, 100);
      ncs   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ncs   = 1'b1;
      rd(1, v);
      chk("ulr write while busy", 32'(v), 32'd15);
      while (ec !== 1'b1 && (tcount - t0) < 100) tick();
      chk("busy run ec edge", 32'(tcount - t0), 32'd42);
      chk("busy run ec", 32'(ec), 32'd1);
      chk("busy run count", 32'(count), 32'd10);
      tick();
      chk("busy run ec clear", 32'(ec), 32'd0);

      // Write and read strobes together: write wins, no read data
      ncs  = 1'b0;
      nwr  = 1'b0;
      nrd  = 1'b0;
      addr = 3'd3;
      din  = 8'd7;
      tick();
      ncs  = 1'b1;
      nwr  = 1'b1;
      nrd  = 1'b1;
      chk("wr+rd dout", 32'(dout), 32'd0);
      rd(3, v);
      chk("wr+rd ccr", 32'(v), 32'd7);
      tick();
      chk("idle dout", 32'(dout), 32'd0);

      // Deselected: strobes and start are ignored
      nwr   = 1'b0;
      nrd   = 1'b0;
      addr  = 3'd3;
      din   = 8'd9;
      start = 1'b1;
      tick();
      chk("ncs dout", 32'(dout), 32'd0);
      tick();
      chk("ncs busy", 32'(busy), 32'd0);
      nwr   = 1'b1;
      nrd   = 1'b1;
      start = 1'b0;
      rd(3, v);
      chk("ncs ccr", 32'(v), 32'd7);

      // Degenerate limits and PLR at a limit
      run_cfg(5, 5, 5, 1, "deg all");
      run_cfg(1, 5, 1, 1, "deg plr=llr");
      run_cfg(7, 7, 3, 2, "plr=ulr");

      // Illegal limits block start
      wr(0, 20);
      wr(1, 15);
      chk("err set", 32'(err), 32'd1);
      c0 = int'(count);
      go();
      tick();
      tick();
      chk("err no busy", 32'(busy), 32'd0);
      chk("err count", 32'(count), 32'(c0));
      wr(1, 30);
      chk("err cleared", 32'(err), 32'd0);

      // Auto-restart, then abort in DOWN
      wr(0, 2);
      wr(1, 4);
      wr(2, 0);
      wr(3, 1);
      wr(4, 1);
      go();
      t0 = tcount;
      for (int k = 1; k <= 34; k++) begin
         tick();
         chk("auto ec", 32'(ec), 32'((k % 10) == 0));
         if (k == 1 || k == 11 || k == 21) begin
            chk("auto load count", 32'(count), 32'd2);
            chk("auto load busy", 32'(busy), 32'd1);
         end
      end
      chk("auto edge count", 32'(tcount - t0), 32'd34);
      chk("pre-abort count", 32'(count), 32'd3);
      chk("pre-abort dir", 32'(dir), 32'd0);
      wr(4, 2);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort count", 32'(count), 32'd3);
      chk("abort ec", 32'(ec), 32'd0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("post-abort ec", 32'(ec), 32'd0);
         chk("post-abort count", 32'(count), 32'd3);
         chk("post-abort busy", 32'(busy), 32'd0);
      end
      rd(4, v);
      chk("ctrl readback", 32'(v), 32'd0);

      // Reset during UP
      wr(0, 3);
      wr(1, 9);
      wr(2, 1);
      wr(3, 3);
      go();
      tick();
      tick();
      tick();
      tick();
      chk("pre-reset busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      chk("midrst count", 32'(count), 32'd0);
      chk("midrst dir", 32'(dir), 32'd0);
      chk("midrst ec", 32'(ec), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst dout", 32'(dout), 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 6; a++) begin
         rd(a, v);
         chk("midrst reg", 32'(v), 32'(def_exp[a]));
      end
      check_run(1, 255, 0, 0, "default run");

      // Randomized legal configurations
      for (int r = 0; r < 12; r++) begin
         l = int'($urandom_range(230, 0));
         u = l + int'($urandom_range(20, 0));
         p = int'($urandom_range(u, l));
         c = int'($urandom_range(3, 0));
         run_cfg(p, u, l, c, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
